addsub_acc_stage: RTL and testbench
===================================

// Module: addsub_acc_stage
// PURPOSE
// Registered, handshaked front-end around the combinational 16-bit adder/subtractor (a, b, mode -> sum, cout, of).
// Accepts one operation per cycle on a valid/ready input, computes it and holds the result in an output register with valid/ready.
// Optionally replaces operand A with the running accumulator. Keeps a sticky overflow flag and an accepted-operation counter.
// Sits between the operand source and any result consumer; it is the streaming stage wrapped around the add/sub datapath.
// PARAMETERS
// WIDTH     16  datapath width (sum, operands, accumulator)
// CNT_W     16  width of op_count
// SATURATE  0   1: clamp signed-overflow results to 0x7FFF/0x8000 (for WIDTH=16); 0: wrap
// PORTS
// clk        in   1      single clock, rising edge
// rst_n      in   1      asynchronous, active-low reset
// clr        in   1      sync clear of acc, sticky_of, op_count
// in_valid   in   1      operation offered
// in_ready   out  1      stage can accept this cycle
// in_a       in   WIDTH  operand A (ignored when in_acc=1)
// in_b       in   WIDTH  operand B
// in_mode    in   1      0: A+B, 1: A-B (A + ~B + 1)
// in_acc     in   1      1: use accumulator as operand A
// out_valid  out  1      result register holds an unconsumed result
// out_ready  in   1      consumer takes result
// out_sum    out  WIDTH  registered result
// out_cout   out  1      carry out of MSB (for subtract: 1 = no borrow)
// out_of     out  1      signed overflow of this operation
// acc        out  WIDTH  accumulator = last accepted result
// sticky_of  out  1      set by any accepted op with overflow; cleared by clr/reset
// op_count   out  CNT_W  number of accepted ops, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0, out_sum=0, out_cout=0, out_of=0, acc=0, sticky_of=0, op_count=0. Takes effect immediately, mid-operation included; an in-flight result is discarded.
// - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
// - Latency 1: op accepted at edge N -> out_valid=1 with result after edge N. Back-to-back ops are accepted every cycle while out_ready=1.
// - Output hold: while out_valid=1 && out_ready=0, out_sum/out_cout/out_of are held stable; no accept occurs, and acc/op_count/sticky_of do not change.
// - Output drain: out_ready=1 with no accept -> out_valid 0 next cycle; data regs keep their last value.
// - Arithmetic: A' = in_acc ? acc : in_a; B' = in_mode ? ~in_b : in_b; {cout,raw} = A' + B' + in_mode.
//   of = (A'[MSB] == B'[MSB]) && (raw[MSB] != A'[MSB]).
// - SATURATE=1 && of: out_sum = A'[MSB] ? 0x8000 : 0x7FFF; out_cout and out_of are reported unchanged. SATURATE=0: out_sum = raw.
// - On accept: acc <= out_sum value; op_count <= op_count+1 (wraps); sticky_of <= sticky_of | of.
// - clr without accept: acc, sticky_of and op_count go to 0 next edge; out regs are untouched.
// - clr with a simultaneous accept: clear applies first. Operand A uses 0 if in_acc=1. After the edge, op_count=1, sticky_of = of, and acc = the new result.
// - No internal state machine beyond the out_valid full/empty bit; the stage never drops or duplicates an accepted op.
// TESTING
// 1. in_a=7FFF, in_b=0001, mode=0, SATURATE=0 -> next cycle out_sum=8000, out_cout=0, out_of=1, sticky_of=1, op_count=1.
// 2. in_a=0000, in_b=0001, mode=1 -> out_sum=FFFF, out_cout=0, out_of=0; then in_a=0005, in_b=0003, mode=1 -> out_sum=0002, out_cout=1.
// 3. clr; then in_acc=1, in_b=0005, mode=0 -> 0005; then in_acc=1, in_b=0003, mode=1 -> 0002; acc=0002, op_count=2.
// 4. Backpressure: result pending, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0; out_sum stable; op_count unchanged; the 4th cycle with out_ready=1 accepts.
// 5. Assert rst_n=0 mid-cycle while out_valid=1, acc=1234 -> out_valid, acc, op_count and sticky_of go to 0 without waiting for a clock edge.
// 6. SATURATE=1: in_a=8000, in_b=0001, mode=1 -> out_sum=8000, out_of=1; in_a=7FFF, in_b=7FFF, mode=0 -> out_sum=7FFF, out_of=1.

Source files
------------

// File: rtl/addsub_acc_stage.sv
// Streaming add/subtract stage: one operation per cycle through a valid/ready input.
// The result lands in a registered output slot alongside an accumulator, a sticky overflow flag and an op counter.
module addsub_acc_stage #(
    parameter int WIDTH    = 16,
    parameter int CNT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_of,
    output logic [WIDTH-1:0] acc,
    output logic             sticky_of,
    output logic [CNT_W-1:0] op_count
);

    logic signed [WIDTH-1:0] a_p0;
    logic signed [WIDTH-1:0] b_p0;
    logic signed [WIDTH-1:0] raw_p0;
    logic signed [WIDTH-1:0] res_p0;
    logic        [WIDTH:0]   ext_p0;
    logic                    cout_p0;
    logic                    of_p0;
    logic                    accept;

    logic                    vld_p1;
    logic signed [WIDTH-1:0] sum_p1;
    logic                    cout_p1;
    logic                    of_p1;
    logic signed [WIDTH-1:0] acc_p1;
    logic                    sticky_p1;
    logic        [CNT_W-1:0] cnt_p1;

    // Overflowed results clamp toward the sign of operand A, which is the sign both operands share.
    function automatic logic signed [WIDTH-1:0] sat_fn(
        input logic signed [WIDTH-1:0] raw,
        input logic                    a_neg,
        input logic                    ovf
    );
        logic signed [WIDTH-1:0] r;
        r = raw;
        if (SATURATE != 0 && ovf) begin
            r = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage 0: operand selection and add/subtract.
    always_comb begin
        a_p0    = in_acc ? (clr ? '0 : acc_p1) : in_a;
        b_p0    = in_mode ? ~in_b : in_b;
        ext_p0  = {1'b0, a_p0} + {1'b0, b_p0} + (WIDTH+1)'(in_mode);
        raw_p0  = ext_p0[WIDTH-1:0];
        cout_p0 = ext_p0[WIDTH];
        of_p0   = (a_p0[WIDTH-1] == b_p0[WIDTH-1]) && (raw_p0[WIDTH-1] != a_p0[WIDTH-1]);
        res_p0  = sat_fn(raw_p0, a_p0[WIDTH-1], of_p0);
    end

    // Stage 1: output slot, accumulator and bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            sum_p1    <= '0;
            cout_p1   <= 1'b0;
            of_p1     <= 1'b0;
            acc_p1    <= '0;
            sticky_p1 <= 1'b0;
            cnt_p1    <= '0;
        end else begin
            if (accept) begin
                vld_p1  <= 1'b1;
                sum_p1  <= res_p0;
                cout_p1 <= cout_p0;
                of_p1   <= of_p0;
            end else if (out_ready) begin
                vld_p1  <= 1'b0;
            end

            // A clear in the same cycle as an accept wipes the old state before the new op counts.
            if (accept) begin
                acc_p1    <= res_p0;
                cnt_p1    <= (clr ? '0 : cnt_p1) + CNT_W'(1);
                sticky_p1 <= (clr ? 1'b0 : sticky_p1) | of_p0;
            end else if (clr) begin
                acc_p1    <= '0;
                cnt_p1    <= '0;
                sticky_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_cout  = cout_p1;
    assign out_of    = of_p1;
    assign acc       = acc_p1;
    assign sticky_of = sticky_p1;
    assign op_count  = cnt_p1;

endmodule

// File: tb/tb_addsub_acc_stage.sv
// Bench for addsub_acc_stage: a wrapping instance (CNT_W=16) and a saturating instance (CNT_W=4)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_addsub_acc_stage;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_mode;
    logic        in_acc;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        ov0, ov1;
    logic [15:0] sum0, sum1;
    logic        co0, co1;
    logic        of0, of1;
    logic [15:0] acc0, acc1;
    logic        st0, st1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int checks;
    int errors;

    // Reference model state, index 0 = wrapping instance, 1 = saturating instance.
    logic        mv;
    logic [15:0] ms   [2];
    logic        mc   [2];
    logic        mo   [2];
    logic [15:0] macc [2];
    logic        mst  [2];
    int          mcnt [2];
    logic        rdy_seen;
    logic        rdy_exp;

    addsub_acc_stage #(.WIDTH(16), .CNT_W(16), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_acc(in_acc),
        .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_cout(co0),
        .out_of(of0), .acc(acc0), .sticky_of(st0), .op_count(cnt0)
    );

    addsub_acc_stage #(.WIDTH(16), .CNT_W(4), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_acc(in_acc),
        .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_cout(co1),
        .out_of(of1), .acc(acc1), .sticky_of(st1), .op_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain signed/unsigned integer arithmetic: overflow is "result out of 16-bit signed range",
    // carry is "unsigned sum exceeds 16 bits" or, for subtract, "no borrow".
    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input logic mode,
                                   input logic sat, output logic [15:0] s, output logic co,
                                   output logic ov);
        int sa, sb, r, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = int'(a);
        ub = int'(b);
        r  = mode ? sa - sb : sa + sb;
        co = mode ? (ua >= ub) : (ua + ub > 65535);
        ov = (r > 32767) || (r < -32768);
        if (sat && ov) s = (r > 0) ? 16'h7FFF : 16'h8000;
        else           s = r[15:0];
    endfunction

    function automatic logic [51:0] act_vec(input int k);
        if (k == 0) return {ov0, sum0, co0, of0, acc0, st0, cnt0};
        return {ov1, sum1, co1, of1, acc1, st1, 12'h000, cnt1};
    endfunction

    function automatic logic [51:0] exp_vec(input int k);
        logic [15:0] c;
        c = (k == 0) ? mcnt[k][15:0] : (mcnt[k][15:0] & 16'h000F);
        return {mv, ms[k], mc[k], mo[k], macc[k], mst[k], c};
    endfunction

    task automatic model_reset();
        mv = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ms[k] = '0; mc[k] = 1'b0; mo[k] = 1'b0; macc[k] = '0; mst[k] = 1'b0; mcnt[k] = 0;
        end
    endtask

    // Drives one cycle of stimulus (starting 1 time unit after a rising edge) and advances the model.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic mode, input logic use_acc, input logic c, input logic ordy);
        logic        acc_ok;
        logic [15:0] opa, s;
        logic        co, ov;
        in_valid = v; in_a = a; in_b = b; in_mode = mode; in_acc = use_acc;
        clr = c; out_ready = ordy;
        #4;
        rdy_seen = in_ready0 & in_ready1;
        rdy_exp  = !mv || ordy;
        acc_ok   = v && rdy_exp;
        for (int k = 0; k < 2; k++) begin
            opa = use_acc ? (c ? 16'h0000 : macc[k]) : a;
            ref_op(opa, b, mode, k == 1, s, co, ov);
            if (acc_ok) begin
                ms[k] = s; mc[k] = co; mo[k] = ov; macc[k] = s;
                mcnt[k] = ((c ? 0 : mcnt[k]) + 1) % ((k == 0) ? 65536 : 16);
                mst[k]  = (c ? 1'b0 : mst[k]) | ov;
            end else if (c) begin
                macc[k] = '0; mcnt[k] = 0; mst[k] = 1'b0;
            end
        end
        if (acc_ok) mv = 1'b1;
        else if (ordy) mv = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; in_acc = 0; clr = 0; out_ready = 1;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== 52'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h, want 0", k, act_vec(k));
            end
        end
        checks++;
        if ((in_ready0 & in_ready1) !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", in_ready0 & in_ready1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_overflow_add();
        do_reset();
        cycle(1, 16'h7FFF, 16'h0001, 0, 0, 0, 1);
        checks++;
        if ({ov0, sum0, co0, of0, st0, cnt0} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL overflow_add: got v=%b sum=%h co=%b of=%b st=%b cnt=%0d, want 1 8000 0 1 1 1",
                     ov0, sum0, co0, of0, st0, cnt0);
        end
        checks++;
        if (sum1 !== 16'h7FFF || of1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_add_sat: got sum=%h of=%b, want 7fff 1", sum1, of1);
        end
    endtask

    task automatic test_subtract();
        do_reset();
        cycle(1, 16'h0000, 16'h0001, 1, 0, 0, 1);
        checks++;
        if ({sum0, co0, of0} !== {16'hFFFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got sum=%h co=%b of=%b, want ffff 0 0", sum0, co0, of0);
        end
        cycle(1, 16'h0005, 16'h0003, 1, 0, 0, 1);
        checks++;
        if ({sum0, co0, of0} !== {16'h0002, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_noborrow: got sum=%h co=%b of=%b, want 0002 1 0", sum0, co0, of0);
        end
        cycle(0, 16'h0000, 16'h0000, 0, 0, 0, 1);
        checks++;
        if (act_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL drain: got %h, want %h", act_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_accumulate();
        cycle(0, 16'h0000, 16'h0000, 0, 0, 1, 1);
        checks++;
        if ({acc0, st0, cnt0} !== {16'h0000, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL clr: got acc=%h st=%b cnt=%0d, want 0 0 0", acc0, st0, cnt0);
        end
        cycle(1, 16'hABCD, 16'h0005, 0, 1, 0, 1);
        checks++;
        if (sum0 !== 16'h0005) begin
            errors++;
            $display("FAIL acc_add: got %h, want 0005", sum0);
        end
        cycle(1, 16'hABCD, 16'h0003, 1, 1, 0, 1);
        checks++;
        if ({sum0, acc0, cnt0} !== {16'h0002, 16'h0002, 16'd2}) begin
            errors++;
            $display("FAIL acc_sub: got sum=%h acc=%h cnt=%0d, want 0002 0002 2", sum0, acc0, cnt0);
        end
        // Clear together with an accumulate: operand A must read as zero.
        cycle(1, 16'h0000, 16'h0009, 0, 1, 1, 1);
        checks++;
        if ({sum0, acc0, cnt0} !== {16'h0009, 16'h0009, 16'd1}) begin
            errors++;
            $display("FAIL clr_with_accept: got sum=%h acc=%h cnt=%0d, want 0009 0009 1", sum0, acc0, cnt0);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        int          cnt_before;
        cycle(1, 16'h1111, 16'h2222, 0, 0, 0, 0);
        held = sum0;
        cnt_before = int'(cnt0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 16'h0F0F, 16'h0101, 0, 0, 0, 0);
            checks++;
            if (rdy_seen !== 1'b0 || sum0 !== held || int'(cnt0) !== cnt_before || ov0 !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_%0d: got rdy=%b sum=%h cnt=%0d v=%b, want 0 %h %0d 1",
                         i, rdy_seen, sum0, cnt0, ov0, held, cnt_before);
            end
        end
        cycle(1, 16'h0F0F, 16'h0101, 0, 0, 0, 1);
        checks++;
        if (rdy_seen !== 1'b1 || sum0 !== 16'h1010 || int'(cnt0) !== cnt_before + 1) begin
            errors++;
            $display("FAIL backpressure_release: got rdy=%b sum=%h cnt=%0d, want 1 1010 %0d",
                     rdy_seen, sum0, cnt0, cnt_before + 1);
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 16'h0000, 16'h0000, 0, 0, 1, 1);
        cycle(1, 16'h1234, 16'h0000, 0, 0, 0, 0);
        checks++;
        if (acc0 !== 16'h1234 || ov0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got acc=%h v=%b, want 1234 1", acc0, ov0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov0, acc0, cnt0, st0, ov1} !== 35'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b acc=%h cnt=%0d st=%b, want 0 0 0 0", ov0, acc0, cnt0, st0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_saturate();
        do_reset();
        cycle(1, 16'h8000, 16'h0001, 1, 0, 0, 1);
        checks++;
        if ({sum1, of1} !== {16'h8000, 1'b1} || sum0 !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_neg: got sat=%h of=%b wrap=%h, want 8000 1 7fff", sum1, of1, sum0);
        end
        cycle(1, 16'h7FFF, 16'h7FFF, 0, 0, 0, 1);
        checks++;
        if ({sum1, of1, st1} !== {16'h7FFF, 1'b1, 1'b1} || sum0 !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pos: got sat=%h of=%b st=%b wrap=%h, want 7fff 1 1 fffe", sum1, of1, st1, sum0);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            a = $urandom_range(0, 3) == 0 ? {$urandom_range(0, 1) ? 16'h7FFF : 16'h8000} : 16'($urandom);
            b = 16'($urandom);
            cycle($urandom_range(0, 3) != 0, a, b, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random[%0d] inst%0d: got %h, want %h", i, k, act_vec(k), exp_vec(k));
                end
            end
            checks++;
            if (rdy_seen !== rdy_exp) begin
                errors++;
                $display("FAIL random_ready[%0d]: got %b, want %b", i, rdy_seen, rdy_exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_overflow_add();
        test_subtract();
        test_accumulate();
        test_backpressure();
        test_async_reset();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
